// File: rtl/isqrt_pipe_with_valid.sv
// Pipelined integer square root, one root bit per stage, MSB first, latency width/2.
// Optional remainder output: define ISQRT_REMAINDER_EN to add out_rem.
module isqrt_pipe_with_valid #(
   parameter int width = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_vld,
   input  logic [width-1:0]   in_data,
   output logic               out_vld,
   output logic [width/2-1:0] out_data
`ifdef ISQRT_REMAINDER_EN
   ,
   output logic [width/2:0]   out_rem
`endif
);

   localparam int N = width / 2;
`ifdef ISQRT_REMAINDER_EN
   localparam bit REM_EN = 1'b1;
`else
   localparam bit REM_EN = 1'b0;
`endif

   // Restoring digit recurrence: bring down two radicand bits, try root*4+1.
   for (genvar k = 0; k < N; k++) begin : g_stg
      localparam int B = N - 1 - k;

      logic           vld_i;
      logic [1:0]     pair_i;
      logic [N-1:0]   root_i;
      logic [N:0]     rem_i;
      logic [N+2:0]   t;
      logic [N+1:0]   trial;
      logic           ge;
      logic           vld_q;
      logic [N-1:0]   root_q;

      if (k == 0) begin : g_in
         assign vld_i  = in_vld;
         assign pair_i = in_data[width-1 -: 2];
         assign root_i = '0;
         assign rem_i  = '0;
      end else begin : g_in
         assign vld_i  = g_stg[k-1].vld_q;
         assign pair_i = g_stg[k-1].g_x.x_q[2*B+1 -: 2];
         assign root_i = g_stg[k-1].root_q;
         assign rem_i  = g_stg[k-1].g_rem.rem_q;
      end

      assign t     = {rem_i, pair_i};
      assign trial = {root_i, 2'b01};
      assign ge    = (t >= {1'b0, trial});

      always_ff @(posedge clk) begin
         if (rst) vld_q <= 1'b0;
         else     vld_q <= vld_i;
         if (vld_i) root_q <= {root_i[N-2:0], ge};
      end

      // Unconsumed radicand bits travel alongside; the last stage needs none.
      if (B > 0) begin : g_x
         logic [2*B-1:0] x_q;
         if (k == 0) begin : g_src
            always_ff @(posedge clk) if (vld_i) x_q <= in_data[2*B-1:0];
         end else begin : g_src
            always_ff @(posedge clk) if (vld_i) x_q <= g_stg[k-1].g_x.x_q[2*B-1:0];
         end
      end

      // Remainder fits N+1 bits (<= 2*root), so the low-bit subtract is exact.
      if (k < N - 1 || REM_EN) begin : g_rem
         logic [N:0] rem_q;
         always_ff @(posedge clk)
            if (vld_i) rem_q <= ge ? (t[N:0] - trial[N:0]) : t[N:0];
      end
   end

   assign out_vld  = g_stg[N-1].vld_q;
   assign out_data = g_stg[N-1].root_q;
`ifdef ISQRT_REMAINDER_EN
   assign out_rem  = g_stg[N-1].g_rem.rem_q;
`endif

endmodule

// File: tb/tb_isqrt_pipe_with_valid.sv
// Scoreboard bench: width=8 and width=32 instances, expected results queued at the input edge.
module tb_isqrt_pipe_with_valid;

   localparam int N8  = 4;
   localparam int N32 = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        vld8, vld32;
   logic [7:0]  d8;
   logic [31:0] d32;
   logic        ov8, ov32;
   logic [3:0]  od8;
   logic [15:0] od32;
`ifdef ISQRT_REMAINDER_EN
   logic [4:0]  or8;
   logic [16:0] or32;
`endif

   typedef struct {
      int    due;
      longint root;
      longint rem;
   } exp_t;

   exp_t q8[$];
   exp_t q32[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   isqrt_pipe_with_valid #(.width(8)) dut8 (
      .clk(clk), .rst(rst), .in_vld(vld8), .in_data(d8),
      .out_vld(ov8), .out_data(od8)
`ifdef ISQRT_REMAINDER_EN
      , .out_rem(or8)
`endif
   );

   isqrt_pipe_with_valid #(.width(32)) dut32 (
      .clk(clk), .rst(rst), .in_vld(vld32), .in_data(d32),
      .out_vld(ov32), .out_data(od32)
`ifdef ISQRT_REMAINDER_EN
      , .out_rem(or32)
`endif
   );

   always #5 clk = ~clk;

   function automatic longint isqrt(input longint x);
      longint r;
      r = longint'($floor($sqrt(real'(x))));
      while (r * r > x) r--;
      while ((r + 1) * (r + 1) <= x) r++;
      return r;
   endfunction

   function automatic exp_t mk(input longint x, input int due);
      exp_t e;
      e.due  = due;
      e.root = isqrt(x);
      e.rem  = x - e.root * e.root;
      return e;
   endfunction

   // Reference: each accepted input is due n-1 edges after the edge that samples it.
   always @(posedge clk) begin
      cyc = cyc + 1;
      if (rst) begin
         q8.delete();
         q32.delete();
      end else begin
         if (vld8)  q8.push_back(mk(longint'(d8), cyc + N8 - 1));
         if (vld32) q32.push_back(mk(longint'(d32), cyc + N32 - 1));
      end
   end

   always @(negedge clk) begin
      if (cyc >= 1) begin
         bit   ev;
         exp_t e;
         ev = (q8.size() > 0) && (q8[0].due == cyc);
         checks++;
         if (ov8 !== ev) begin
            errors++;
            $display("FAIL w8_vld cycle %0d: got %b expected %b", cyc, ov8, ev);
         end
         if (ev) begin
            e = q8.pop_front();
            if (ov8 === 1'b1) begin
               checks++;
               if (longint'(od8) != e.root) begin
                  errors++;
                  $display("FAIL w8_root cycle %0d: got %0d expected %0d", cyc, od8, e.root);
               end
`ifdef ISQRT_REMAINDER_EN
               checks++;
               if (longint'(or8) != e.rem) begin
                  errors++;
                  $display("FAIL w8_rem cycle %0d: got %0d expected %0d", cyc, or8, e.rem);
               end
`endif
            end
         end
      end
   end

   always @(negedge clk) begin
      if (cyc >= 1) begin
         bit   ev;
         exp_t e;
         ev = (q32.size() > 0) && (q32[0].due == cyc);
         checks++;
         if (ov32 !== ev) begin
            errors++;
            $display("FAIL w32_vld cycle %0d: got %b expected %b", cyc, ov32, ev);
         end
         if (ev) begin
            e = q32.pop_front();
            if (ov32 === 1'b1) begin
               checks++;
               if (longint'(od32) != e.root) begin
                  errors++;
                  $display("FAIL w32_root cycle %0d: got %0d expected %0d", cyc, od32, e.root);
               end
`ifdef ISQRT_REMAINDER_EN
               checks++;
               if (longint'(or32) != e.rem) begin
                  errors++;
                  $display("FAIL w32_rem cycle %0d: got %0d expected %0d", cyc, or32, e.rem);
               end
`endif
            end
         end
      end
   end

   task automatic step8(input bit v, input logic [7:0] a);
      vld8 = v; d8 = a; vld32 = 1'b0; d32 = '0;
      @(negedge clk);
   endtask

   task automatic step32(input bit v, input logic [31:0] b);
      vld8 = 1'b0; d8 = '0; vld32 = v; d32 = b;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step8(1'b0, 8'd0);
   endtask

   initial begin
      logic [7:0]  bnd [8];
      bit          pat [6];
      logic [31:0] k;
      bnd = '{8'd0, 8'd1, 8'd3, 8'd4, 8'd15, 8'd16, 8'd224, 8'd225};
      pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      rst = 1'b1; vld8 = 1'b0; d8 = '0; vld32 = 1'b0; d32 = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      step8(1'b1, 8'd255);
      idle(8);
      foreach (bnd[i]) step8(1'b1, bnd[i]);
      idle(6);
      for (int i = 0; i < 256; i++) step8(1'b1, 8'(i));
      idle(6);
      for (int i = 0; i < 100; i++) step8(1'($urandom_range(0, 1)), 8'($urandom));
      step8(1'b1, 8'd200);
      step8(1'b1, 8'd255);
      step8(1'b1, 8'd0);
      idle(6);

      for (int i = 0; i < 6; i++)
         step32(pat[i], (i == 0) ? 32'hFFFF_FFFF : $urandom);
      for (int i = 0; i < 300; i++) begin
         k = 32'($urandom_range(1, 65535));
         case ($urandom_range(0, 3))
            0:       step32(1'($urandom_range(0, 3) != 0), k * k);
            1:       step32(1'($urandom_range(0, 3) != 0), k * k - 32'd1);
            2:       step32(1'($urandom_range(0, 3) != 0), 32'hFFFF_FFFF - $urandom_range(0, 3));
            default: step32(1'($urandom_range(0, 3) != 0), $urandom);
         endcase
      end
      idle(20);

      // Flush in-flight work with a one-cycle reset that also carries a valid.
      step8(1'b1, 8'd50);
      step8(1'b1, 8'd81);
      step8(1'b1, 8'd99);
      rst = 1'b1;
      step8(1'b1, 8'd144);
      rst = 1'b0;
      idle(10);
      step8(1'b1, 8'd100);
      idle(8);

      checks++;
      if (q8.size() != 0 || q32.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d/%0d pending expected 0/0", q8.size(), q32.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
